// File: rtl/map_pkg.sv
// ============================================================================
// Module      : map_pkg
// Description : Map geometry, command opcodes and painter FSM states shared
//               by the map painter and the map renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package map_pkg;

  localparam int MAP_WIDTH  = 160;
  localparam int MAP_HEIGHT = 90;
  localparam int MAP_DEPTH  = MAP_WIDTH * MAP_HEIGHT;
  localparam int MAP_ADDR_W = $clog2(MAP_DEPTH);

  typedef enum logic [1:0] {
    OP_PLOT  = 2'd0,
    OP_RECT  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } map_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLOT  = 2'd1,
    ST_RECT  = 2'd2,
    ST_CLEAR = 2'd3
  } map_state_e;

endpackage

`default_nettype wire

// File: rtl/map_painter_if.sv
// ============================================================================
// Module      : map_painter_if
// Description : Command handshake and map-RAM port-A write bus of the painter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface map_painter_if
  import map_pkg::*;
#(
  parameter int ADDR_W = MAP_ADDR_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_x0;
  logic [7:0]        cmd_x1;
  logic [6:0]        cmd_y0;
  logic [6:0]        cmd_y1;
  logic [3:0]        cmd_color;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic              wr_en;
  logic              done;

  // Command issuer side
  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    input  cmd_ready, wr_addr, wr_data, wr_en, done
  );

  // Painter side
  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    output cmd_ready, wr_addr, wr_data, wr_en, done
  );

endinterface

`default_nettype wire

// File: rtl/map_painter.sv
// ============================================================================
// Module      : map_painter
// Description : Paints PLOT / RECT / CLEAR commands into the texel map RAM,
//               one texel per cycle, through RAM port A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_painter
  import map_pkg::*;
#(
  parameter int   WIDTH  = MAP_WIDTH,
  parameter int   HEIGHT = MAP_HEIGHT,
  localparam int  AW     = $clog2(WIDTH * HEIGHT)
) (
  input  wire logic          pixel_clk_in,
  input  wire logic          rst_in,
  input  wire logic          cmd_valid_in,
  output logic               cmd_ready_out,
  input  wire logic [1:0]    cmd_op_in,
  input  wire logic [7:0]    cmd_x0_in,
  input  wire logic [7:0]    cmd_x1_in,
  input  wire logic [6:0]    cmd_y0_in,
  input  wire logic [6:0]    cmd_y1_in,
  input  wire logic [3:0]    cmd_color_in,
  output logic [AW-1:0]      wr_addr_out,
  output logic [3:0]         wr_data_out,
  output logic               wr_en_out,
  output logic               done_out
);

  localparam logic [7:0]    XMAX     = 8'(WIDTH - 1);
  localparam logic [6:0]    YMAX     = 7'(HEIGHT - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(WIDTH);

  map_state_e    state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    x0_q, x0_d;
  logic [7:0]    x1_q, x1_d;
  logic [6:0]    y_q, y_d;
  logic [6:0]    y1_q, y1_d;
  logic [AW-1:0] base_q, base_d;
  logic [3:0]    color_q, color_d;
  logic          hit_q, hit_d;

  logic          wr_en;
  logic          done;
  logic [7:0]    x0_clamp;
  logic [7:0]    x1_clamp;
  logic [6:0]    y0_clamp;
  logic [6:0]    y1_clamp;

  assign x0_clamp = (cmd_x0_in > XMAX) ? XMAX : cmd_x0_in;
  assign x1_clamp = (cmd_x1_in > XMAX) ? XMAX : cmd_x1_in;
  assign y0_clamp = (cmd_y0_in > YMAX) ? YMAX : cmd_y0_in;
  assign y1_clamp = (cmd_y1_in > YMAX) ? YMAX : cmd_y1_in;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y_q     <= '0;
      y1_q    <= '0;
      base_q  <= '0;
      color_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y_q     <= y_d;
      y1_q    <= y1_d;
      base_q  <= base_d;
      color_q <= color_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y_d     = y_q;
    y1_d    = y1_q;
    base_d  = base_q;
    color_d = color_q;
    hit_d   = hit_q;
    wr_en   = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_in) begin
          color_d = cmd_color_in;
          hit_d   = 1'b0;
          // Commands that write nothing park in PLOT with hit clear so they
          // still complete with a single done pulse one cycle later.
          case (map_op_e'(cmd_op_in))
            OP_PLOT: begin
              state_d = ST_PLOT;
              hit_d   = (cmd_x0_in <= XMAX) && (cmd_y0_in <= YMAX);
              x_d     = x0_clamp;
              base_d  = AW'(y0_clamp) * ROW_STEP;
            end
            OP_RECT: begin
              if ((cmd_x0_in > cmd_x1_in) || (cmd_y0_in > cmd_y1_in)) begin
                state_d = ST_PLOT;
              end else begin
                state_d = ST_RECT;
                x_d     = x0_clamp;
                x0_d    = x0_clamp;
                x1_d    = x1_clamp;
                y_d     = y0_clamp;
                y1_d    = y1_clamp;
                base_d  = AW'(y0_clamp) * ROW_STEP;
              end
            end
            OP_CLEAR: begin
              state_d = ST_CLEAR;
              x_d     = '0;
              x0_d    = '0;
              x1_d    = XMAX;
              y_d     = '0;
              y1_d    = YMAX;
              base_d  = '0;
            end
            default: begin
              state_d = ST_PLOT;
            end
          endcase
        end
      end

      ST_PLOT: begin
        wr_en   = hit_q;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      ST_RECT, ST_CLEAR: begin
        wr_en = 1'b1;
        if (x_q == x1_q) begin
          if (y_q == y1_q) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            x_d    = x0_q;
            y_d    = y_q + 7'd1;
            base_d = base_q + ROW_STEP;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset gates the strobes immediately so an aborted command cannot finish.
  assign cmd_ready_out = (state_q == ST_IDLE) && !rst_in;
  assign wr_en_out     = wr_en && !rst_in;
  assign done_out      = done && !rst_in;
  assign wr_addr_out   = wr_en ? (base_q + AW'(x_q)) : '0;
  assign wr_data_out   = wr_en ? color_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_map_painter.sv
// ============================================================================
// Module      : tb_map_painter
// Description : Directed self-checking bench for map_painter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_map_painter;
  import map_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  map_painter_if bus ();

  map_painter #(
    .WIDTH  (MAP_WIDTH),
    .HEIGHT (MAP_HEIGHT)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .cmd_valid_in  (bus.cmd_valid),
    .cmd_ready_out (bus.cmd_ready),
    .cmd_op_in     (bus.cmd_op),
    .cmd_x0_in     (bus.cmd_x0),
    .cmd_x1_in     (bus.cmd_x1),
    .cmd_y0_in     (bus.cmd_y0),
    .cmd_y1_in     (bus.cmd_y1),
    .cmd_color_in  (bus.cmd_color),
    .wr_addr_out   (bus.wr_addr),
    .wr_data_out   (bus.wr_data),
    .wr_en_out     (bus.wr_en),
    .done_out      (bus.done)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned wa[$];
  int unsigned wd[$];
  int          first_cyc;
  int          done_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then hold junk on the command bus while busy and log
  // every write until done (bounded).
  task automatic run(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] x1,
                     input logic [6:0] y0, input logic [6:0] y1, input logic [3:0] col,
                     input string tag);
    wa.delete();
    wd.delete();
    first_cyc = -1;
    done_at   = -1;
    chk({tag, "_ready_pre"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x0    = x0;
    bus.cmd_x1    = x1;
    bus.cmd_y0    = y0;
    bus.cmd_y1    = y1;
    bus.cmd_color = col;
    step();
    bus.cmd_op    = 2'd2;
    bus.cmd_x0    = 8'($urandom);
    bus.cmd_x1    = 8'($urandom);
    bus.cmd_y0    = 7'($urandom);
    bus.cmd_y1    = 7'($urandom);
    bus.cmd_color = 4'($urandom);
    for (int c = 1; c <= 20000; c++) begin
      if (bus.wr_en) begin
        if (first_cyc < 0) first_cyc = c;
        wa.push_back(32'(bus.wr_addr));
        wd.push_back(32'(bus.wr_data));
      end
      if (bus.done) begin
        done_at = c;
        break;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_at > 0), 32'd1);
    step();
    chk({tag, "_ready_post"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_idle_wr_en"}, 32'(bus.wr_en), 32'd0);
  endtask

  function automatic int data_errs(input int unsigned col);
    int n = 0;
    foreach (wd[i]) if (wd[i] != col) n++;
    return n;
  endfunction

  initial begin
    int seen;
    int errs;
    int strobes;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_x0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_data", 32'(bus.wr_data), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_release_ready", 32'(bus.cmd_ready), 32'd1);

    // PLOT (10,5) color 7 -> addr 5*160+10 = 810
    run(2'd0, 8'd10, 8'd0, 7'd5, 7'd0, 4'd7, "plot");
    chk("plot_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("plot_addr", wa[0], 32'd810);
      chk("plot_data", wd[0], 32'd7);
    end
    chk("plot_first_cyc", 32'(first_cyc), 32'd1);
    chk("plot_done_cyc", 32'(done_at), 32'd1);

    // RECT x 2..4, y 1..2, color 3
    run(2'd1, 8'd2, 8'd4, 7'd1, 7'd2, 4'd3, "rect");
    chk("rect_count", 32'(wa.size()), 32'd6);
    if (wa.size() == 6) begin
      chk("rect_a0", wa[0], 32'd162);
      chk("rect_a1", wa[1], 32'd163);
      chk("rect_a2", wa[2], 32'd164);
      chk("rect_a3", wa[3], 32'd322);
      chk("rect_a4", wa[4], 32'd323);
      chk("rect_a5", wa[5], 32'd324);
    end
    chk("rect_data", 32'(data_errs(3)), 32'd0);
    chk("rect_first_cyc", 32'(first_cyc), 32'd1);
    chk("rect_done_cyc", 32'(done_at), 32'd6);

    // RECT clipped to x 150..159, y 88..89 -> 20 writes
    run(2'd1, 8'd150, 8'd200, 7'd88, 7'd120, 4'd9, "clip");
    chk("clip_count", 32'(wa.size()), 32'd20);
    if (wa.size() == 20) begin
      chk("clip_first", wa[0], 32'd14230);
      chk("clip_row1", wa[10], 32'd14390);
      chk("clip_last", wa[19], 32'd14399);
    end
    chk("clip_data", 32'(data_errs(9)), 32'd0);
    chk("clip_done_cyc", 32'(done_at), 32'd20);

    // Empty RECT, off-map PLOT, reserved op
    run(2'd1, 8'd5, 8'd3, 7'd0, 7'd0, 4'd1, "empty_rect");
    chk("empty_rect_count", 32'(wa.size()), 32'd0);
    chk("empty_rect_done", 32'(done_at), 32'd1);
    run(2'd0, 8'd160, 8'd0, 7'd0, 7'd0, 4'd1, "plot_off");
    chk("plot_off_count", 32'(wa.size()), 32'd0);
    chk("plot_off_done", 32'(done_at), 32'd1);
    run(2'd3, 8'd1, 8'd2, 7'd1, 7'd2, 4'd1, "rsvd");
    chk("rsvd_count", 32'(wa.size()), 32'd0);
    chk("rsvd_done", 32'(done_at), 32'd1);

    // CLEAR color 0 -> 0..14399 ascending
    run(2'd2, 8'd0, 8'd0, 7'd0, 7'd0, 4'd0, "clear");
    chk("clear_count", 32'(wa.size()), 32'd14400);
    errs = 0;
    foreach (wa[i]) if (wa[i] != i) errs++;
    chk("clear_seq", 32'(errs), 32'd0);
    chk("clear_data", 32'(data_errs(0)), 32'd0);
    chk("clear_done_cyc", 32'(done_at), 32'd14400);

    // Reset during CLEAR at the 500th write
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_color = 4'd2;
    step();
    bus.cmd_valid = 1'b0;
    seen    = 0;
    strobes = 0;
    for (int c = 0; c < 600; c++) begin
      if (bus.done) strobes++;
      if (bus.wr_en) seen++;
      if (seen == 500) break;
      step();
    end
    chk("abort_reached", 32'(seen), 32'd500);
    chk("abort_addr", 32'(bus.wr_addr), 32'd499);
    chk("abort_data", 32'(bus.wr_data), 32'd2);
    chk("abort_no_early_done", 32'(strobes), 32'd0);
    rst = 1'b1;
    step();
    chk("abort_wr_en", 32'(bus.wr_en), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
    chk("abort_addr_zero", 32'(bus.wr_addr), 32'd0);
    rst = 1'b0;
    step();
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.wr_en || bus.done) strobes++;
      step();
    end
    chk("abort_quiet", 32'(strobes), 32'd0);

    // Follow-up PLOTs, including the far map corner
    run(2'd0, 8'd0, 8'd0, 7'd0, 7'd0, 4'd15, "plot_after");
    chk("plot_after_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("plot_after_addr", wa[0], 32'd0);
      chk("plot_after_data", wd[0], 32'd15);
    end
    run(2'd0, 8'd159, 8'd0, 7'd89, 7'd0, 4'd1, "plot_corner");
    chk("plot_corner_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) chk("plot_corner_addr", wa[0], 32'd14399);
    chk("plot_corner_done", 32'(done_at), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/map_painter.md
MAP_PAINTER -- requirements
Module: map_painter

Interface
REQ-001 SHALL have parameter WIDTH, default 160, map width in texels.
REQ-002 SHALL have parameter HEIGHT, default 90, map height in texels.
REQ-003 SHALL have port pixel_clk_in, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid_in, input, 1 bit: command present.
REQ-006 SHALL have port cmd_ready_out, output, 1 bit: command accepted when high together with cmd_valid_in.
REQ-007 SHALL have port cmd_op_in, input, 2 bits: 0=PLOT, 1=RECT, 2=CLEAR, 3=reserved.
REQ-008 SHALL have ports cmd_x0_in and cmd_x1_in, inputs, 8 bits each: column bounds, inclusive.
REQ-009 SHALL have ports cmd_y0_in and cmd_y1_in, inputs, 7 bits each: row bounds, inclusive.
REQ-010 SHALL have port cmd_color_in, input, 4 bits: palette index to write.
REQ-011 SHALL have port wr_addr_out, output, $clog2(WIDTH*HEIGHT) bits: map RAM write address.
REQ-012 SHALL have port wr_data_out, output, 4 bits: map RAM write data.
REQ-013 SHALL have port wr_en_out, output, 1 bit: map RAM write strobe.
REQ-014 SHALL have port done_out, output, 1 bit: one-cycle pulse at command completion.

Function
REQ-015 SHALL implement FSM states IDLE, PLOT, RECT, CLEAR; cmd_ready_out=1 only in IDLE.
REQ-016 SHALL latch all cmd_* fields on acceptance (cycle N) and ignore cmd inputs until back in IDLE.
REQ-017 SHALL emit wr_en_out=1 for exactly one texel per cycle from cycle N+1 until the last texel, with wr_addr_out=y*WIDTH+x and wr_data_out=latched color.
REQ-018 PLOT SHALL write texel (x0,y0) at N+1, with done_out at N+1.
REQ-019 RECT SHALL scan x0..x1 inner and y0..y1 outer, row-major, writing (x1-x0+1)*(y1-y0+1) texels on consecutive cycles.
REQ-020 CLEAR SHALL write addresses 0..WIDTH*HEIGHT-1 ascending, WIDTH*HEIGHT cycles.
REQ-021 done_out SHALL assert in the same cycle as the final write; FSM SHALL be back in IDLE (ready=1) the following cycle.
REQ-022 Clipping: x bounds SHALL be clamped to WIDTH-1 and y bounds to HEIGHT-1 before scanning; PLOT outside the map SHALL produce no write.
REQ-023 RECT with x0>x1 or y0>y1, PLOT fully clipped, or op=3 SHALL produce zero writes and pulse done_out at N+1.
REQ-024 Address arithmetic SHALL be unsigned and no wider than wr_addr_out; the row base SHALL be held in an incremental register (+WIDTH per row), not a per-cycle multiply.
REQ-025 Scan counters SHALL wrap x to x0 and increment y on reaching x1; terminate on (x1,y1).

Reset
REQ-026 On rst_in, FSM SHALL go to IDLE and wr_en_out, done_out, wr_addr_out, wr_data_out SHALL be 0 the following cycle.
REQ-027 Reset mid-command SHALL abort it: no further writes, no done_out pulse.
REQ-028 cmd_ready_out SHALL be 0 while rst_in=1 and 1 the cycle after rst_in deasserts.

Structure
REQ-029 Package map_pkg SHALL hold MAP_WIDTH=160, MAP_HEIGHT=90, MAP_DEPTH, the 2-bit op enum and the FSM state enum, shared with the map renderer.
REQ-030 Single module; no sub-module. Output ports connect to port A of a true-dual-port map RAM whose port B serves the renderer read path.

Verification
REQ-031 PLOT (10,5,color 7) -> one write, addr 810, data 7, at N+1; done at N+1; ready at N+2.
REQ-032 RECT x 2..4, y 1..2, color 3 -> addrs 162,163,164,322,323,324 on N+1..N+6; done at N+6.
REQ-033 CLEAR color 0 -> 14400 writes, addr 0..14399 ascending, no gaps; done at N+14400.
REQ-034 RECT x 150..200, y 88..120 -> clamped to x 150..159, y 88..89: 20 writes, last addr 14399.
REQ-035 RECT x0=5 > x1=3 -> zero writes, done at N+1; PLOT (160,0) -> zero writes, done at N+1.
REQ-036 rst_in during CLEAR at write 500 -> wr_en_out=0 next cycle, no done, ready=1 after deassert; follow-up PLOT succeeds.
